// File: rtl/mb_mode_arbiter.sv
// Macroblock intra-mode arbiter: collects NUM_CAND luma picker results plus one
// chroma result, picks the lowest-score candidate and hands the merged result downstream.
module mb_mode_arbiter #(
    parameter int         NUM_CAND     = 2,
    parameter int         SCORE_W      = 64,
    parameter int         PAYLOAD_W    = 2048,
    parameter logic [7:0] DC_CAND_MASK = 8'd1,
    parameter int         TIMEOUT      = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CAND-1:0]           cand_done,
    input  logic [NUM_CAND*SCORE_W-1:0]   cand_score,
    input  logic [NUM_CAND*32-1:0]        cand_nz,
    input  logic [NUM_CAND*PAYLOAD_W-1:0] cand_payload,
    input  logic                          uv_done,
    input  logic [31:0]                   uv_nz,
    input  logic                          force_en,
    input  logic [2:0]                    force_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2:0]                    sel_idx,
    output logic [7:0]                    mbtype,
    output logic [31:0]                   nz,
    output logic                          skipped,
    output logic [PAYLOAD_W-1:0]          payload,
    output logic                          timeout_err,
    output logic                          busy
);

    localparam int IW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_OUTPUT
    } state_t;

    state_t state_q, next_state;

    // Per-candidate result storage
    logic signed [SCORE_W-1:0]   score_q [NUM_CAND];
    logic        [31:0]          cnz_q   [NUM_CAND];
    logic        [PAYLOAD_W-1:0] pay_q   [NUM_CAND];
    logic        [7:0]           uv_nz_q;

    logic [NUM_CAND-1:0]         rx_q;
    logic                        uv_rx_q;
    logic                        force_en_q;
    logic [2:0]                  force_idx_q;
    logic [CW-1:0]               cnt_q;
    logic                        to_q;

    logic [IW-1:0]               k_q;
    logic                        best_vld_q;
    logic [IW-1:0]               best_idx_q;
    logic signed [SCORE_W-1:0]   best_score_q;

    logic          accept;
    logic          all_rx;
    logic          tmo_hit;
    logic          leave_collect;
    logic          last_k;
    logic          take_k;
    logic          force_ok;
    logic          any_cand;
    logic [IW-1:0] fin_idx;
    logic [IW-1:0] sel_w;
    logic [31:0]   sel_cnz;
    logic [7:0]    uv_bits;
    logic [31:0]   nz_merged;

    // Capture window: all of COLLECT, plus the IDLE cycle that carries start.
    assign accept        = (state_q == S_COLLECT) || ((state_q == S_IDLE) && start);
    assign all_rx        = (&rx_q) && uv_rx_q;
    assign tmo_hit       = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign leave_collect = (state_q == S_COLLECT) && !start && (all_rx || tmo_hit);

    assign last_k = (k_q == IW'(NUM_CAND - 1));
    assign take_k = rx_q[k_q] && (!best_vld_q || (score_q[k_q] < best_score_q));

    assign fin_idx  = take_k ? k_q : best_idx_q;
    assign any_cand = best_vld_q || take_k;
    assign force_ok = force_en_q && ({1'b0, force_idx_q} < 4'(NUM_CAND))
                      && rx_q[force_idx_q[IW-1:0]];
    assign sel_w    = force_ok ? force_idx_q[IW-1:0] : fin_idx;

    // Chroma bits read as zero when the chroma picker never reported.
    assign sel_cnz   = cnz_q[sel_w];
    assign uv_bits   = uv_rx_q ? uv_nz_q : 8'd0;
    assign nz_merged = {7'd0, DC_CAND_MASK[sel_w] & sel_cnz[24], uv_bits, sel_cnz[15:0]};

    assign busy = (state_q != S_IDLE);

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state_q;
        unique case (state_q)
            S_IDLE:    if (start) next_state = S_COLLECT;
            S_COLLECT: begin
                if (start)                    next_state = S_COLLECT;
                else if (all_rx || tmo_hit)   next_state = S_DECIDE;
            end
            S_DECIDE:  if (last_k) next_state = S_OUTPUT;
            S_OUTPUT:  if (out_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // NOTE: candidate storage has no reset; the rx flags gate every read, so stale data is never used.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CAND; i++) begin
            if (accept && cand_done[i] && (start || !rx_q[i])) begin
                score_q[i] <= cand_score[i*SCORE_W +: SCORE_W];
                cnz_q[i]   <= cand_nz[i*32 +: 32];
                pay_q[i]   <= cand_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        if (accept && uv_done) uv_nz_q <= uv_nz[23:16];
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_q         <= '0;
            uv_rx_q      <= 1'b0;
            force_en_q   <= 1'b0;
            force_idx_q  <= 3'd0;
            cnt_q        <= '0;
            to_q         <= 1'b0;
            k_q          <= '0;
            best_vld_q   <= 1'b0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            out_valid    <= 1'b0;
            sel_idx      <= 3'd0;
            mbtype       <= 8'd0;
            nz           <= 32'd0;
            skipped      <= 1'b0;
            payload      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state_q <= next_state;

            if (accept) begin
                if (start) begin
                    rx_q        <= '0;
                    uv_rx_q     <= 1'b0;
                    cnt_q       <= '0;
                    to_q        <= 1'b0;
                    force_en_q  <= force_en;
                    force_idx_q <= force_idx;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                for (int i = 0; i < NUM_CAND; i++) begin
                    if (cand_done[i]) rx_q[i] <= 1'b1;
                end
                if (uv_done) uv_rx_q <= 1'b1;
            end

            if (leave_collect) to_q <= !all_rx;

            if ((state_q == S_IDLE) || (state_q == S_COLLECT)) begin
                k_q        <= '0;
                best_vld_q <= 1'b0;
            end

            if (state_q == S_DECIDE) begin
                k_q <= k_q + 1'b1;
                if (take_k) begin
                    best_vld_q   <= 1'b1;
                    best_idx_q   <= k_q;
                    best_score_q <= score_q[k_q];
                end
                if (last_k) begin
                    out_valid   <= 1'b1;
                    timeout_err <= to_q;
                    if (any_cand) begin
                        sel_idx <= 3'(sel_w);
                        mbtype  <= {7'd0, DC_CAND_MASK[sel_w]};
                        nz      <= nz_merged;
                        skipped <= (nz_merged == 32'd0);
                        payload <= pay_q[sel_w];
                    end else begin
                        sel_idx <= 3'd0;
                        mbtype  <= 8'd0;
                        nz      <= 32'd0;
                        skipped <= 1'b0;
                        payload <= '0;
                    end
                end
            end

            if ((state_q == S_OUTPUT) && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mb_mode_arbiter.sv
// Bench for mb_mode_arbiter: directed scenarios plus randomized macroblocks
// checked against a score-table reference model.
module tb_mb_mode_arbiter;

    localparam int         NC  = 2;
    localparam int         SW  = 64;
    localparam int         PW  = 64;
    localparam int         TMO = 16;
    localparam logic [7:0] DCM = 8'd1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NC-1:0]     cand_done;
    logic [NC*SW-1:0]  cand_score;
    logic [NC*32-1:0]  cand_nz;
    logic [NC*PW-1:0]  cand_payload;
    logic              uv_done;
    logic [31:0]       uv_nz;
    logic              force_en;
    logic [2:0]        force_idx;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        sel_idx;
    logic [7:0]        mbtype;
    logic [31:0]       nz;
    logic              skipped;
    logic [PW-1:0]     payload;
    logic              timeout_err;
    logic              busy;

    always #5 clk = ~clk;

    mb_mode_arbiter #(
        .NUM_CAND(NC), .SCORE_W(SW), .PAYLOAD_W(PW), .DC_CAND_MASK(DCM), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cand_done(cand_done), .cand_score(cand_score), .cand_nz(cand_nz),
        .cand_payload(cand_payload), .uv_done(uv_done), .uv_nz(uv_nz),
        .force_en(force_en), .force_idx(force_idx),
        .out_valid(out_valid), .out_ready(out_ready), .sel_idx(sel_idx),
        .mbtype(mbtype), .nz(nz), .skipped(skipped), .payload(payload),
        .timeout_err(timeout_err), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: what the arbiter has accepted for the current macroblock
    bit          m_rx  [NC];
    longint      m_score [NC];
    bit [31:0]   m_nz  [NC];
    bit [63:0]   m_pl  [NC];
    bit          m_uv_rx;
    bit [31:0]   m_uv;
    bit          m_fe;
    int          m_fi;

    // Values to drive on the next pulse
    longint      d_score [NC];
    bit [31:0]   d_nz  [NC];
    bit [63:0]   d_pl  [NC];
    bit [31:0]   d_uv;

    // Expected result
    int          e_sel;
    bit [7:0]    e_mbt;
    bit [31:0]   e_nz;
    bit          e_skip;
    bit [63:0]   e_pl;
    bit          e_to;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cand(input int i, input longint s, input bit [31:0] n, input bit [63:0] p);
        d_score[i] = s;
        d_nz[i]    = n;
        d_pl[i]    = p;
    endtask

    task automatic begin_mb(input bit fe, input int fi);
        start     = 1'b1;
        force_en  = fe;
        force_idx = 3'(fi);
        for (int i = 0; i < NC; i++) m_rx[i] = 1'b0;
        m_uv_rx = 1'b0;
        m_fe    = fe;
        m_fi    = fi;
        tick();
        start     = 1'b0;
        force_en  = 1'b0;
        force_idx = 3'd0;
    endtask

    task automatic pulse(input bit [NC-1:0] cm, input bit uvf);
        for (int i = 0; i < NC; i++) begin
            cand_score[i*SW +: SW]   = d_score[i];
            cand_nz[i*32 +: 32]      = d_nz[i];
            cand_payload[i*PW +: PW] = d_pl[i];
            if (cm[i] && !m_rx[i]) begin
                m_rx[i]    = 1'b1;
                m_score[i] = d_score[i];
                m_nz[i]    = d_nz[i];
                m_pl[i]    = d_pl[i];
            end
        end
        uv_nz     = d_uv;
        cand_done = cm;
        uv_done   = uvf;
        if (uvf) begin
            m_uv_rx = 1'b1;
            m_uv    = d_uv;
        end
        tick();
        cand_done = '0;
        uv_done   = 1'b0;
    endtask

    task automatic compute_exp();
        int best;
        bit all;
        best = -1;
        all  = m_uv_rx;
        for (int i = 0; i < NC; i++) begin
            if (!m_rx[i]) all = 1'b0;
            if (m_rx[i] && (best < 0 || m_score[i] < m_score[best])) best = i;
        end
        if (m_fe && m_fi < NC) begin
            if (m_rx[m_fi]) best = m_fi;
        end
        e_to = !all;
        if (best < 0) begin
            e_sel = 0; e_mbt = 8'd0; e_nz = 32'd0; e_skip = 1'b0; e_pl = 64'd0;
        end else begin
            e_sel = best;
            e_mbt = {7'd0, DCM[best]};
            e_nz  = m_nz[best] & 32'h0000_FFFF;
            if (m_uv_rx) e_nz = e_nz + (((m_uv >> 16) & 32'hFF) << 16);
            if (DCM[best]) e_nz = e_nz + (m_nz[best] & 32'h0100_0000);
            e_skip = (e_nz == 32'd0);
            e_pl   = m_pl[best];
        end
    endtask

    task automatic check_result(input string tag, input bit chk_lat);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "/valid"}, 64'(out_valid), 64'd1);
        if (chk_lat) check({tag, "/latency"}, 64'(n), 64'(NC + 1));
        compute_exp();
        check({tag, "/sel_idx"}, 64'(sel_idx), 64'(e_sel));
        check({tag, "/mbtype"}, 64'(mbtype), 64'(e_mbt));
        check({tag, "/nz"}, 64'(nz), 64'(e_nz));
        check({tag, "/skipped"}, 64'(skipped), 64'(e_skip));
        check({tag, "/payload"}, 64'(payload), e_pl);
        check({tag, "/timeout_err"}, 64'(timeout_err), 64'(e_to));
        check({tag, "/busy"}, 64'(busy), 64'd1);
    endtask

    task automatic accept_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "/idle"}, 64'(busy), 64'd0);
    endtask

    bit [2:0] p, f, need;
    bit [1:0] sent;
    bit       dropped;
    bit       fe_r;
    int       fi_r;

    initial begin
        rst = 1'b1; start = 1'b0; cand_done = '0; cand_score = '0; cand_nz = '0;
        cand_payload = '0; uv_done = 1'b0; uv_nz = '0; force_en = 1'b0;
        force_idx = 3'd0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset/valid", 64'(out_valid), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/sel_idx", 64'(sel_idx), 64'd0);
        check("reset/nz", 64'(nz), 64'd0);
        check("reset/payload", 64'(payload), 64'd0);
        check("reset/timeout_err", 64'(timeout_err), 64'd0);

        // Out-of-order arrival, DC candidate wins
        begin_mb(1'b0, 0);
        set_cand(1, 700, 32'h0000_00F0, 64'h1111);
        pulse(2'b10, 1'b0);
        set_cand(0, 500, 32'h0100_0003, 64'hAAAA_5555);
        pulse(2'b01, 1'b0);
        d_uv = 32'h0005_0000;
        pulse(2'b00, 1'b1);
        check_result("basic", 1'b1);
        check("basic/nz_const", 64'(nz), 64'h0105_0003);
        accept_out("basic");

        // Tie keeps lower index
        begin_mb(1'b0, 0);
        set_cand(0, 300, 32'h3, 64'h1); set_cand(1, 300, 32'h5, 64'h2); d_uv = 32'h0;
        pulse(2'b11, 1'b1);
        check_result("tie", 1'b1);
        accept_out("tie");

        // Negative score wins, non-DC candidate drops nz bit 24
        begin_mb(1'b0, 0);
        set_cand(0, 300, 32'h3, 64'h1); set_cand(1, -5, 32'h0100_0007, 64'h2); d_uv = 32'h00AB_0000;
        pulse(2'b11, 1'b1);
        check_result("neg", 1'b1);
        check("neg/bit24", 64'(nz[24]), 64'd0);
        accept_out("neg");

        // All-zero nz, skipped, and backpressure hold with ignored start
        begin_mb(1'b0, 0);
        set_cand(0, 9, 32'h0, 64'h77); set_cand(1, 2, 32'h0, 64'h88); d_uv = 32'h0;
        pulse(2'b11, 1'b1);
        check_result("skip", 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start = 1'b1; cand_done = '1;
                tick();
                start = 1'b0; cand_done = '0;
            end else begin
                tick();
            end
            check("hold/valid", 64'(out_valid), 64'd1);
            check("hold/sel_idx", 64'(sel_idx), 64'(e_sel));
            check("hold/payload", 64'(payload), e_pl);
        end
        accept_out("skip");

        // Forced selection, in and out of range
        begin_mb(1'b1, 1);
        set_cand(0, 10, 32'h1, 64'h10); set_cand(1, 900, 32'h2, 64'h20); d_uv = 32'h0;
        pulse(2'b11, 1'b1);
        check_result("force1", 1'b1);
        accept_out("force1");
        begin_mb(1'b1, 5);
        pulse(2'b11, 1'b1);
        check_result("force5", 1'b1);
        accept_out("force5");

        // Timeout with only candidate 1, then with nothing at all
        begin_mb(1'b0, 0);
        set_cand(1, 42, 32'h0100_0009, 64'h99);
        pulse(2'b10, 1'b0);
        check_result("tmo1", 1'b0);
        accept_out("tmo1");
        begin_mb(1'b0, 0);
        check_result("tmo0", 1'b0);
        accept_out("tmo0");

        // Repeat done ignored
        begin_mb(1'b0, 0);
        set_cand(0, 500, 32'h1, 64'h1);
        pulse(2'b01, 1'b0);
        set_cand(0, 100, 32'h2, 64'h2); set_cand(1, 300, 32'h3, 64'h3); d_uv = 32'h0;
        pulse(2'b11, 1'b1);
        check_result("repeat", 1'b1);
        accept_out("repeat");

        // Restart mid-collection
        begin_mb(1'b0, 0);
        set_cand(0, 1, 32'h1, 64'h1);
        pulse(2'b01, 1'b0);
        begin_mb(1'b0, 0);
        set_cand(0, 50, 32'h4, 64'h4); set_cand(1, 20, 32'h5, 64'h5); d_uv = 32'h0012_0000;
        pulse(2'b11, 1'b1);
        check_result("restart", 1'b1);
        accept_out("restart");

        // Reset while a result is pending
        begin_mb(1'b0, 0);
        set_cand(0, 7, 32'hF, 64'hF); set_cand(1, 8, 32'hE, 64'hE); d_uv = 32'h0;
        pulse(2'b11, 1'b1);
        check_result("rstout", 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstout/valid", 64'(out_valid), 64'd0);
        check("rstout/busy", 64'(busy), 64'd0);
        check("rstout/nz", 64'(nz), 64'd0);

        // Randomized macroblocks
        for (int it = 0; it < 40; it++) begin
            fe_r = ($urandom_range(0, 2) == 0);
            fi_r = $urandom_range(0, 7);
            begin_mb(fe_r, fi_r);
            need    = 3'b111;
            dropped = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                need[$urandom_range(0, 2)] = 1'b0;
                dropped = 1'b1;
            end
            p    = need;
            sent = 2'b00;
            while (p != 3'b000) begin
                if ($urandom_range(0, 2) == 0) tick();
                f = 3'($urandom) & p;
                if (f == 3'b000) f = p & (~p + 3'd1);
                for (int i = 0; i < NC; i++) begin
                    case ($urandom_range(0, 2))
                        0:       d_score[i] = longint'($urandom_range(0, 6)) - 3;
                        1:       d_score[i] = {$urandom, $urandom};
                        default: d_score[i] = -longint'($urandom);
                    endcase
                    d_nz[i] = $urandom;
                    d_pl[i] = {$urandom, $urandom};
                end
                d_uv = $urandom;
                pulse(f[1:0] | (sent & 2'($urandom)), f[2]);
                sent = sent | f[1:0];
                p    = p & ~f;
            end
            check_result("rand", !dropped);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("rand/hold", 64'(nz), 64'(e_nz));
            end
            accept_out("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
